// File: rtl/fft_out_reorder_if.sv
// Frame-in / bin-out handshake bundle for the FFT output reorder buffer.
// The buffer itself takes the slave view; its upstream and downstream neighbours take the master view.
interface fft_out_reorder_if #(
    parameter int DW = 32,
    parameter int N  = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_index;
    logic [15:0]     out_real;
    logic [15:0]     out_imag;
    logic            out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_index, out_real, out_imag, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_index, out_real, out_imag, out_last
    );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong output buffer for the 16-point FFT: captures a whole bit-reversed frame in one cycle
// and streams it back out one bin per cycle in natural frequency order.
module fft_out_reorder #(
    parameter int DW = 32,
    parameter int N  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    fft_out_reorder_if.slave   bus
);
    logic [N*DW-1:0] bank0_q, bank1_q;
    logic [1:0]      full_q, full_d;
    logic            wsel_q, wsel_d;
    logic            rsel_q, rsel_d;
    logic [3:0]      cnt_q, cnt_d;

    logic            cap;
    logic            rd_hs;
    logic            rd_done;
    logic [3:0]      slot;
    logic [DW-1:0]   word;

    assign cap     = bus.in_valid && !full_q[wsel_q];
    assign rd_hs   = full_q[rsel_q] && bus.out_ready;
    assign rd_done = rd_hs && (cnt_q == 4'd15);
    // The last butterfly stage leaves bin f in slot bitrev4(f).
    assign slot    = {cnt_q[0], cnt_q[1], cnt_q[2], cnt_q[3]};

    always_comb begin
        word = bank0_q[slot*DW +: DW];
        if (rsel_q) begin
            word = bank1_q[slot*DW +: DW];
        end
    end

    // A capture needs full[wsel]=0 and a final drain needs full[rsel]=1, so when both
    // happen in one cycle they always touch different banks and can both be applied.
    always_comb begin
        full_d = full_q;
        wsel_d = wsel_q;
        rsel_d = rsel_q;
        cnt_d  = cnt_q;
        if (cap) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = !wsel_q;
        end
        if (rd_hs) begin
            cnt_d = cnt_q + 4'd1;
        end
        if (rd_done) begin
            full_d[rsel_q] = 1'b0;
            rsel_d         = !rsel_q;
        end
    end

    always_ff @(posedge clk) begin
        if (cap && !wsel_q) begin
            bank0_q <= bus.in_data;
        end
        if (cap && wsel_q) begin
            bank1_q <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 2'b00;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            full_q <= full_d;
            wsel_q <= wsel_d;
            rsel_q <= rsel_d;
            cnt_q  <= cnt_d;
        end
    end

    // Outputs depend on registered state only; they read as zero whenever no bin is offered.
    assign bus.in_ready  = !full_q[wsel_q];
    assign bus.out_valid = full_q[rsel_q];
    assign bus.out_index = full_q[rsel_q] ? cnt_q : 4'd0;
    assign bus.out_real  = full_q[rsel_q] ? word[DW-1 -: 16] : 16'd0;
    assign bus.out_imag  = full_q[rsel_q] ? word[15:0] : 16'd0;
    assign bus.out_last  = full_q[rsel_q] && (cnt_q == 4'd15);
endmodule

// File: doc/fft_out_reorder.md
# fft_out_reorder

Output buffer for the 16-point radix-2 FFT, placed directly downstream of the final butterfly stage. It captures a whole frame of 16 complex results in one cycle and stores it in one of two ping-pong banks. It then streams the frame out one bin per cycle in natural frequency order, undoing the bit-reversed order of the last stage. A ready/valid handshake on both sides lets the next frame load while the previous one drains.

## Interface
Parameters:
- DW, 32, packed complex word width: real in [31:16], imag in [15:0], both two's complement.
- N, 16, points per frame; fixed at 16 (4-bit index).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  frame present on in_data.
- in_ready  output  1  a bank is free; frame accepted on in_valid && in_ready.
- in_data  input  N*DW  final-stage outputs; slot k occupies [32k+31:32k], k=0..15.
- out_valid  output  1  out_* carries a valid bin.
- out_ready  input  1  downstream accepts the bin on out_valid && out_ready.
- out_index  output  4  frequency bin number f, 0..15.
- out_real  output  16  real part of bin f.
- out_imag  output  16  imag part of bin f.
- out_last  output  1  high with bin f=15.

## Operation
State registers:
- bank0, bank1: 16×DW each.
- full[1:0]: per-bank occupancy flags.
- wsel: write-bank pointer, 1 bit.
- rsel: read-bank pointer, 1 bit.
- cnt: 4-bit read counter.

Capture:
- in_ready = !full[wsel].
- On in_valid && in_ready, all 16 slots are written into bank[wsel] in one cycle, full[wsel] is set, and wsel toggles.
- in_valid while in_ready=0 is ignored. Upstream must hold in_data.

Drain:
- out_valid = full[rsel].
- out_index = cnt.
- Bin f is read from slot bitrev4(f) of bank[rsel], where bitrev4(b3b2b1b0) = b0b1b2b3.
- out_real = word[31:16]; out_imag = word[15:0]. Data is passed through with no arithmetic or rescaling.
- On out_valid && out_ready, cnt increments.
- When cnt=15 and the handshake occurs: cnt wraps to 0, full[rsel] clears, rsel toggles.
- out_last = out_valid && cnt==15.
- When out_valid=0, out_index, out_real, out_imag and out_last are all 0.

Simultaneous events:
- A capture into bank[wsel] and the final drain of bank[rsel] may occur in the same cycle. They always target different banks, and both take effect.
- When both banks are full, in_ready=0 until the last bin of bank[rsel] is accepted. In that case in_ready rises the cycle after that handshake, not in the same cycle.

Reset (asserted at any time, including mid-frame):
- Asynchronously clears full, wsel, rsel and cnt. A partially drained frame is discarded.
- Bank contents are not reset.
- Outputs during and after reset: in_ready=1, out_valid=0, out_index=0, out_real=0, out_imag=0, out_last=0.

## Timing
- in_ready and all out_* are functions of registered state only. There is no combinational path from in_valid, in_data or out_ready to any output.
- Latency: frame accepted at edge E gives out_valid=1 and bin 0 in the cycle after E, when the buffer was empty.
- Throughput: with out_ready held at 1, one bin per cycle, and each frame drains in 16 cycles.
- With a new frame offered every 16 cycles and out_ready=1, out_valid stays continuously high across frame boundaries. Bin 0 of frame n+1 follows bin 15 of frame n with no bubble.
- A burst of up to 2 frames is accepted back-to-back on consecutive cycles. A third frame waits for in_ready.

## Test plan
- Single frame, with slot k = {16'(k), 16'(-k)} and out_ready=1 -> one cycle after capture, 16 consecutive bins with out_index 0..15. For example, f=1 gives real 0x0008, imag 0xFFF8; f=3 gives real 0x000C, imag 0xFFF4. out_last is high only at f=15. The next cycle has out_valid=0.
- Two frames offered on consecutive cycles (frame A slots = 0x1000+k, frame B slots = 0x2000+k) -> both accepted, in_ready=0 after the second. 32 bins stream out with no gap, all of A before B.
- Backpressure: out_ready toggles with a 1-cycle-on, 2-cycle-off pattern -> every bin appears exactly once in order. out_index/out_real/out_imag stay stable while out_valid && !out_ready.
- Both banks full and a third frame held on in_valid -> third frame not accepted. in_ready rises the cycle after bin 15 of the first frame is accepted. The third frame is captured then and drains after the second.
- rst_n pulsed low asynchronously (mid-cycle) at bin 7 of a frame -> out_valid=0 and in_ready=1 immediately. After release, a new frame drains from bin 0 with no stale bins.
- Capture and final drain in the same cycle (bank1 loading while bank0 emits f=15) -> neither event is lost. Bank1's bin 0 appears the next cycle.
